gate_bist_ctrl: RTL

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

---
 rtl/gate_bist_ctrl_if.sv | 24 ++
 rtl/gate_bist_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/gate_bist_ctrl_if.sv
// Handshake and stimulus/response bundle between a BIST controller and its driver.
// The gate under test sits on a/b -> y_in.
interface gate_bist_ctrl_if;
  logic       start;
  logic [5:0] y_in;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] fail_mask;
  logic [4:0] err_count;
  logic [1:0] vec_idx;

  modport master (
    output start, y_in,
    input  a, b, busy, done, pass, fail_mask, err_count, vec_idx
  );

  modport slave (
    input  start, y_in,
    output a, b, busy, done, pass, fail_mask, err_count, vec_idx
  );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive 2-input AND-gate BIST: walks {a,b} through 00..11, waits SETTLE cycles,
// compares six responses against a&b and accumulates sticky fail flags and an error count.
module gate_bist_ctrl #(
  parameter int SETTLE = 3
) (
  input logic           clk,
  input logic           rst,
  gate_bist_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t     st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic [5:0] fm_q, fm_d;
  logic [4:0] ec_q, ec_d;
  logic [5:0] mism;
  logic       a_q, b_q, busy_q, done_q, pass_q;
  logic       active_d;

  function automatic logic [4:0] popcnt(input logic [5:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 6; i++) s = s + 5'(v[i]);
    return s;
  endfunction

  // a_q/b_q are the vector actually on the gate, so they define the expected response.
  assign mism = bus.y_in ^ {6{a_q & b_q}};

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    fm_d  = fm_q;
    ec_d  = ec_q;
    case (st_q)
      IDLE, DONE: begin
        if (bus.start) begin
          st_d  = APPLY;
          vec_d = '0;
          fm_d  = '0;
          ec_d  = '0;
        end
      end
      APPLY: begin
        cnt_d = WAIT_INIT;
        st_d  = (SETTLE == 0) ? SAMPLE : WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) st_d = SAMPLE;
        else               cnt_d = cnt_q - 4'd1;
      end
      SAMPLE: begin
        fm_d = fm_q | mism;
        ec_d = ec_q + popcnt(mism);
        if (vec_q == 2'd3) begin
          st_d = DONE;
        end else begin
          vec_d = vec_q + 2'd1;
          st_d  = APPLY;
        end
      end
      default: st_d = IDLE;
    endcase
    active_d = (st_d == APPLY) || (st_d == WAIT) || (st_d == SAMPLE);
  end

  // Every output is registered from next-state values so it lines up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      vec_q  <= '0;
      fm_q   <= '0;
      ec_q   <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      vec_q  <= vec_d;
      fm_q   <= fm_d;
      ec_q   <= ec_d;
      a_q    <= active_d & vec_d[1];
      b_q    <= active_d & vec_d[0];
      busy_q <= active_d;
      done_q <= (st_d == DONE);
      pass_q <= (st_d == DONE) && (fm_d == 6'd0);
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fm_q;
  assign bus.err_count = ec_q;
  assign bus.vec_idx   = vec_q;

endmodule
